// File: rtl/alu_pkg.sv
// Shared types for the ALU/MDU slice: operation select codes, the multiply
// sequencer state set, and a helper that recognises multiply operations.
package alu_pkg;

    typedef enum logic [4:0] {
        C_NOP   = 5'd0,
        C_ADD_U = 5'd1,
        C_SUB_U = 5'd2,
        C_AND   = 5'd3,
        C_OR    = 5'd4,
        C_XOR   = 5'd5,
        C_SLL   = 5'd6,
        C_SRL   = 5'd7,
        C_SRA   = 5'd8,
        C_SLT   = 5'd9,
        C_SLTU  = 5'd10,
        C_MFHI  = 5'd11,
        C_MFLO  = 5'd12,
        C_JR    = 5'd13,
        C_BEQ   = 5'd14,
        C_BNE   = 5'd15,
        C_BLEZ  = 5'd16,
        C_BGTZ  = 5'd17,
        C_BLTZ  = 5'd18,
        C_BGEZ  = 5'd19,
        C_MULT  = 5'd20,
        C_MUL_U = 5'd21
    } alu_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic logic is_mult(input alu_sel_t s);
        return (s == C_MULT) || (s == C_MUL_U);
    endfunction

endpackage

// File: rtl/alu_mult_seq.sv
// Iterative shift-add multiplier: one partial product per cycle on operand
// magnitudes, sign restored at the end for signed requests.
// 'done' is asserted during the final iteration, with 'product' holding the
// finished value, so the parent can register it on that same edge.
module alu_mult_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               is_signed,
    output logic [2*WIDTH-1:0] product,
    output logic               done,
    output logic               busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mul_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_next;

    // Next-state, datapath step and completion signalling
    always_comb begin
        a_neg    = is_signed & op_a[WIDTH-1];
        b_neg    = is_signed & op_b[WIDTH-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        product  = neg_q ? -acc_next : acc_next;
        done     = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d  = MUL;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = a_neg ^ b_neg;
                end
            end
            MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
        end
    end

    assign busy = (state_q == MUL);

endmodule

// File: rtl/alu_mdu.sv
// ALU with multiply unit: single-cycle ALU/branch ops plus HI/LO multiply.
// Build option ALU_MDU_FAST_MULT_EN: single-cycle multiply, never busy.
// Without it, multiplies run through the iterative alu_mult_seq.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  alu_sel_t         sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             branch_taken,
    output logic             valid_out,
    output logic             busy
);

    logic [WIDTH-1:0]   result_q, result_d;
    logic               branch_q, branch_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept;
    logic               mul_sel;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign accept  = valid_in & ~busy;
    assign mul_sel = is_mult(sel);

`ifdef ALU_MDU_FAST_MULT_EN
    // Full-width product computed directly from sign- or zero-extended operands
    always_comb begin
        if (sel == C_MULT)
            mul_product = {{WIDTH{in0[WIDTH-1]}}, in0} * {{WIDTH{in1[WIDTH-1]}}, in1};
        else
            mul_product = {{WIDTH{1'b0}}, in0} * {{WIDTH{1'b0}}, in1};
    end
    assign mul_done = accept & mul_sel;
    assign busy     = 1'b0;
`else
    alu_mult_seq #(.WIDTH(WIDTH)) u_mult (
        .clk       (clk),
        .rst       (rst),
        .start     (accept & mul_sel),
        .op_a      (in0),
        .op_b      (in1),
        .is_signed (sel == C_MULT),
        .product   (mul_product),
        .done      (mul_done),
        .busy      (busy)
    );
`endif

    // Result/branch/HI/LO next values; everything holds unless an op lands
    always_comb begin
        result_d = result_q;
        branch_d = branch_q;
        valid_d  = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (mul_done) begin
            hi_d     = mul_product[2*WIDTH-1:WIDTH];
            lo_d     = mul_product[WIDTH-1:0];
            result_d = mul_product[WIDTH-1:0];
            branch_d = 1'b0;
            valid_d  = 1'b1;
        end else if (accept && !mul_sel) begin
            valid_d  = 1'b1;
            branch_d = 1'b0;
            case (sel)
                C_ADD_U: result_d = in0 + in1;
                C_SUB_U: result_d = in0 - in1;
                C_AND:   result_d = in0 & in1;
                C_OR:    result_d = in0 | in1;
                C_XOR:   result_d = in0 ^ in1;
                C_SLL:   result_d = in1 << shamt;
                C_SRL:   result_d = in1 >> shamt;
                C_SRA:   result_d = $unsigned($signed(in1) >>> shamt);
                C_SLT:   result_d = WIDTH'($signed(in0) < $signed(in1));
                C_SLTU:  result_d = WIDTH'(in0 < in1);
                C_MFHI:  result_d = hi_q;
                C_MFLO:  result_d = lo_q;
                C_JR:    result_d = in0;
                C_BEQ: begin
                    result_d = in0 - in1;
                    branch_d = (in0 == in1);
                end
                C_BNE: begin
                    result_d = in0 - in1;
                    branch_d = (in0 != in1);
                end
                C_BLEZ: begin
                    result_d = in0 - in1;
                    branch_d = in0[WIDTH-1] | (in0 == '0);
                end
                C_BGTZ: begin
                    result_d = in0 - in1;
                    branch_d = ~in0[WIDTH-1] & (in0 != '0);
                end
                C_BLTZ: begin
                    result_d = in0 - in1;
                    branch_d = in0[WIDTH-1];
                end
                C_BGEZ: begin
                    result_d = in0 - in1;
                    branch_d = ~in0[WIDTH-1];
                end
                default: result_d = '0;
            endcase
        end
    end

    // Output and HI/LO registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            branch_q <= 1'b0;
            valid_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            result_q <= result_d;
            branch_q <= branch_d;
            valid_q  <= valid_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign result       = result_q;
    assign branch_taken = branch_q;
    assign valid_out    = valid_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (default iterative-multiply build):
// directed vectors plus randomized ops against an arithmetic reference model.
module tb_alu_mdu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    alu_sel_t    sel;
    logic [31:0] in0, in1;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        branch_taken, valid_out, busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference architectural state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .sel          (sel),
        .in0          (in0),
        .in1          (in1),
        .shamt        (shamt),
        .result       (result),
        .branch_taken (branch_taken),
        .valid_out    (valid_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference for single-cycle ops: returns {branch, result}
    function automatic logic [32:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh);
        int sa, sb;
        logic [31:0] r;
        logic br;
        sa = a;
        sb = b;
        br = 1'b0;
        r  = 32'd0;
        case (op)
            1:  r = a + b;
            2:  r = a - b;
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = b << sh;
            7:  r = b >> sh;
            8:  r = sb >>> sh;
            9:  r = (sa < sb) ? 32'd1 : 32'd0;
            10: r = (a < b) ? 32'd1 : 32'd0;
            11: r = m_hi;
            12: r = m_lo;
            13: r = a;
            14: begin r = a - b; br = (a == b); end
            15: begin r = a - b; br = (a != b); end
            16: begin r = a - b; br = (sa <= 0); end
            17: begin r = a - b; br = (sa > 0); end
            18: begin r = a - b; br = (sa < 0); end
            19: begin r = a - b; br = (sa >= 0); end
            default: r = 32'd0;
        endcase
        return {br, r};
    endfunction

    function automatic logic [63:0] ref_mul(input int op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint p;
        sa = a;
        sb = b;
        if (op == 20) begin
            p = longint'(sa) * longint'(sb);
            return p;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Issue one single-cycle op at the current negedge and check it next cycle
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        logic [32:0] e;
        e        = ref_alu(op, a, b, sh);
        sel      = alu_sel_t'(op[4:0]);
        in0      = a;
        in1      = b;
        shamt    = sh;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check($sformatf("op%0d_valid", op), 64'(valid_out), 64'd1);
        check($sformatf("op%0d_result", op), 64'(result), 64'(e[31:0]));
        check($sformatf("op%0d_branch", op), 64'(branch_taken), 64'(e[32]));
    endtask

    // Issue a multiply, optionally spam ADD_U while busy, then read HI/LO back
    task automatic run_mult(input int op, input logic [31:0] a, input logic [31:0] b, input bit spam);
        logic [63:0] p;
        int unsigned cycles;
        int unsigned early;
        p        = ref_mul(op, a, b);
        sel      = alu_sel_t'(op[4:0]);
        in0      = a;
        in1      = b;
        shamt    = '0;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = spam;
        if (spam) begin
            sel = C_ADD_U;
            in0 = $urandom;
            in1 = $urandom;
        end
        cycles = 0;
        early  = 0;
        while (busy && cycles < 40) begin
            cycles++;
            if (valid_out) early++;
            @(negedge clk);
            if (spam) begin
                in0 = $urandom;
                in1 = $urandom;
            end
        end
        valid_in = 1'b0;
        check("mul_busy_cycles", 64'(cycles), 64'd32);
        check("mul_no_early_valid", 64'(early), 64'd0);
        check("mul_done_valid", 64'(valid_out), 64'd1);
        check("mul_done_busy", 64'(busy), 64'd0);
        check("mul_done_result", 64'(result), 64'(p[31:0]));
        m_hi = p[63:32];
        m_lo = p[31:0];
        run_op(11, '0, '0, '0);
        run_op(12, '0, '0, '0);
    endtask

    initial begin
        logic [31:0] edges [6];
        int unsigned vcnt, bcnt;
        edges[0] = 32'h0000_0000; edges[1] = 32'hFFFF_FFFF; edges[2] = 32'h8000_0000;
        edges[3] = 32'h7FFF_FFFF; edges[4] = 32'h0000_0001; edges[5] = 32'h0000_0005;

        rst = 1'b1; valid_in = 1'b0; sel = C_NOP; in0 = '0; in1 = '0; shamt = '0;
        #1;
        check("rst_result", 64'(result), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_branch", 64'(branch_taken), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        run_op(1, 32'hFFFF_FFFF, 32'd1, '0);
        check("add_wrap_const", 64'(result), 64'd0);
        run_op(8, '0, 32'h8000_0000, 5'd4);
        check("sra_const", 64'(result), 64'hF800_0000);
        run_op(9, 32'hFFFF_FFFF, 32'd1, '0);
        check("slt_const", 64'(result), 64'd1);
        run_op(10, 32'hFFFF_FFFF, 32'd1, '0);
        check("sltu_const", 64'(result), 64'd0);
        run_op(14, 32'd5, 32'd5, '0);
        check("beq_const", 64'(branch_taken), 64'd1);
        run_op(17, 32'd0, 32'd3, '0);
        check("bgtz_const", 64'(branch_taken), 64'd0);
        run_op(18, 32'h8000_0000, 32'd0, '0);
        check("bltz_const", 64'(branch_taken), 64'd1);
        run_op(0, 32'd9, 32'd9, '0);
        run_op(27, 32'd9, 32'd9, '0);

        // Outputs hold between operations
        run_op(13, 32'hDEAD_BEEF, '0, '0);
        repeat (3) @(negedge clk);
        check("hold_result", 64'(result), 64'hDEAD_BEEF);
        check("hold_valid", 64'(valid_out), 64'd0);

        run_mult(20, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_hi_const", 64'(m_hi), 64'hFFFF_FFFF);
        run_mult(21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("mulu_lo_const", 64'(m_lo), 64'h0000_0001);

        // Reset in the middle of a multiply
        run_op(1, 32'd1, 32'd2, '0);
        sel = C_MULT; in0 = 32'h1234_5678; in1 = 32'h0000_0321; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_valid", 64'(valid_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        vcnt = 0; bcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_out) vcnt++;
            if (busy) bcnt++;
        end
        check("midrst_no_valid", 64'(vcnt), 64'd0);
        check("midrst_no_busy", 64'(bcnt), 64'd0);
        m_hi = '0;
        m_lo = '0;
        run_op(11, '0, '0, '0);
        run_op(12, '0, '0, '0);
        run_op(1, 32'd40, 32'd2, '0);

        // Randomized single-cycle ops
        for (int i = 0; i < 200; i++) begin
            int op;
            logic [31:0] a, b;
            op = $urandom_range(0, 31);
            if (op == 20 || op == 21) op = 1;
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            run_op(op, a, b, 5'($urandom_range(0, 31)));
        end

        // Randomized multiplies
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            b = $urandom;
            run_mult(20 + (i % 2), a, b, i[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port valid_in  input  1  operation request, sampled each rising edge.
REQ-005 SHALL have port sel  input  5  operation select, type alu_sel_t.
REQ-006 SHALL have port in0  input  WIDTH  operand A (rs).
REQ-007 SHALL have port in1  input  WIDTH  operand B (rt or immediate).
REQ-008 SHALL have port shamt  input  5  shift amount.
REQ-009 SHALL have port result  output  WIDTH  registered result.
REQ-010 SHALL have port branch_taken  output  1  registered branch condition.
REQ-011 SHALL have port valid_out  output  1  one-cycle pulse: result/branch_taken valid.
REQ-012 SHALL have port busy  output  1  multiply in progress; requests ignored.

Function
REQ-013 SHALL accept a request when valid_in=1 and busy=0; requests while busy=1 are dropped without effect.
REQ-014 Single-cycle ops accepted in cycle N SHALL present result and valid_out=1 in cycle N+1.
REQ-015 C_ADD_U/C_SUB_U SHALL compute in0+in1 / in0-in1 modulo 2^WIDTH, no overflow flag.
REQ-016 C_AND/C_OR/C_XOR SHALL be bitwise on in0,in1.
REQ-017 C_SLL/C_SRL/C_SRA SHALL shift in1 by shamt (logical left, logical right, arithmetic right).
REQ-018 C_SLT SHALL return 1 if signed in0<in1 else 0; C_SLTU same unsigned.
REQ-019 C_MFHI/C_MFLO SHALL return HI/LO register contents; C_JR SHALL return in0.
REQ-020 Branch ops SHALL set branch_taken: C_BEQ in0==in1, C_BNE in0!=in1, C_BLEZ signed in0<=0, C_BGTZ in0>0, C_BLTZ in0<0, C_BGEZ in0>=0; result = in0-in1 for these.
REQ-021 branch_taken SHALL be 0 for every non-branch op; C_NOP and undefined codes SHALL give result 0 and still pulse valid_out.
REQ-022 C_MULT (signed) and C_MUL_U (unsigned) SHALL write the 2*WIDTH product into HI (upper) and LO (lower); result on completion = LO.
REQ-023 Multiply FSM states SHALL be IDLE, MUL, DONE: IDLE->MUL on accepted multiply; MUL->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-024 Iterative multiply SHALL be shift-add on operand magnitudes, product negated when signs differ (C_MULT only).
REQ-025 Multiply accepted in cycle N: busy=1 in cycles N+1..N+WIDTH; HI/LO updated and valid_out=1 in cycle N+WIDTH+1 (DONE), busy=0 there.
REQ-026 A new request SHALL be accepted in the DONE cycle; C_MFHI/C_MFLO accepted there SHALL read the new HI/LO.
REQ-027 HI/LO SHALL change only on multiply completion; outputs other than valid_out SHALL hold their last value between operations.

Reset
REQ-028 rst=1 SHALL immediately force result=0, branch_taken=0, valid_out=0, busy=0, HI=0, LO=0, FSM=IDLE, iteration counter=0.
REQ-029 Reset during MUL SHALL abandon the multiply; no valid_out for it after release.
REQ-030 First request SHALL be accepted on the first rising edge with rst=0.

Configuration
REQ-031 Macro ALU_MDU_FAST_MULT_EN defined: multiply SHALL be single-cycle (latency per REQ-014), busy never asserted, MUL/DONE states unused.
REQ-032 Macro undefined: iterative multiply per REQ-023..REQ-025.

Structure
REQ-033 alu_sel_t and the multiply FSM state enum SHALL live in alu_pkg; no local copies of encodings.
REQ-034 Iterative multiplier SHALL be sub-module alu_mult_seq (start, operands, signed flag -> product, done); combinational ops stay in alu_mdu.

Verification
REQ-035 ADD_U in0=0xFFFFFFFF, in1=1 -> next cycle result=0, valid_out=1, branch_taken=0.
REQ-036 SRA in1=0x80000000, shamt=4 -> result=0xF8000000; SLT in0=-1, in1=1 -> 1; SLTU same -> 0.
REQ-037 MULT in0=-3, in1=7 -> busy 32 cycles, cycle N+33 valid_out=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MFHI -> 0xFFFFFFFF.
REQ-038 MUL_U in0=in1=0xFFFFFFFF with ADD_U requests during busy -> adds dropped, HI=0xFFFFFFFE, LO=0x00000001.
REQ-039 BEQ in0=in1=5 -> branch_taken=1; BGTZ in0=0 -> 0; BLTZ in0=0x80000000 -> 1.
REQ-040 rst pulse at iteration 10 of MULT -> busy=0, HI=LO=0 immediately, no valid_out afterwards; next ADD_U completes in 1 cycle.
